fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each requester and of the FIFO write port.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum beats written per grant (1..256).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester data-valid.
REQ-007 req_data  input  NREQ*WIDTH  packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-009 fifo_full  input  1  full flag from the synchronous FIFO.
REQ-010 fifo_w_enb  output  1  FIFO write enable.
REQ-011 fifo_d_in  output  WIDTH  FIFO write data.
REQ-012 grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
REQ-013 busy  output  1  high while in state BURST.

Function
REQ-014 SHALL implement FSM with states IDLE and BURST.
REQ-015 IDLE: if any req_valid is high, SHALL select a winner by round-robin and enter BURST next cycle with grant_id = winner; otherwise it SHALL stay in IDLE.
REQ-016 Round-robin search SHALL start at (last_grant+1) mod NREQ and proceed upward with wrap-around; the first requester found with req_valid high wins.
REQ-017 IDLE: req_ready and fifo_w_enb SHALL be 0; arbitration latency SHALL be exactly 1 cycle from req_valid high to busy high.
REQ-018 BURST: req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-019 A beat transfers when req_valid[grant_id] && req_ready[grant_id]; in that cycle fifo_w_enb SHALL be 1 and fifo_d_in SHALL equal req_data of grant_id (combinational, zero latency).
REQ-020 fifo_w_enb SHALL never be 1 while fifo_full is 1.
REQ-021 fifo_d_in SHALL be req_data of grant_id whenever fifo_w_enb is 0; its value is then don't-care for the FIFO.
REQ-022 Beat counter SHALL be $clog2(MAX_BURST+1) bits wide, SHALL clear on entry to BURST and SHALL increment only on a transfer.
REQ-023 On the transfer that makes the beat count equal MAX_BURST, SHALL return to IDLE next cycle.
REQ-024 BURST with req_valid[grant_id] low SHALL return to IDLE next cycle with no transfer in that cycle (grant released).
REQ-025 BURST with fifo_full high and req_valid[grant_id] high SHALL stall: stay in BURST, count unchanged, no timeout.
REQ-026 last_grant SHALL update to grant_id on every BURST->IDLE transition.
REQ-027 Requests from other requesters during BURST SHALL be ignored until the next IDLE cycle.
REQ-028 After a burst ends, the FSM SHALL spend at least one cycle in IDLE before the next grant.

Reset
REQ-029 Asserting reset SHALL immediately force state IDLE, beat count 0, grant_id 0, last_grant NREQ-1, busy 0, req_ready 0, fifo_w_enb 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no further write; after release, requester 0 SHALL have first priority.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the FSM state typedef (IDLE, BURST) and default values for WIDTH, NREQ and MAX_BURST.
REQ-032 Round-robin selection SHALL be a combinational sub-module fifo_rr_pick with inputs req and last_grant and outputs winner and any_req.

Verification
REQ-033 After reset, with NREQ=4 and req_valid=4'b1010 held, SHALL produce grant order 1,3,1,3; each burst SHALL be 8 beats with fifo_full=0.
REQ-034 Requester 2 alone writes 3 beats (0xA,0xB,0xC) and then drops valid -> SHALL produce exactly 3 fifo_w_enb pulses with data A,B,C, then busy 0 next cycle.
REQ-035 fifo_full is driven high for 5 cycles mid-burst -> req_ready and fifo_w_enb SHALL be 0 for those 5 cycles; the burst SHALL resume and total 8 beats.
REQ-036 With all 4 requesters valid, grant_id sequence SHALL be 0,1,2,3,0, with at least one IDLE cycle between grants.
REQ-037 Reset is asserted after beat 4 of a burst by requester 1 -> outputs SHALL clear in the same cycle; after release with all valid, the first grant SHALL go to requester 0.
REQ-038 MAX_BURST=1 with req_valid=4'b0001 held -> SHALL produce a single-beat grant every second cycle, and fifo_w_enb SHALL toggle 1,0,1,0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter defaults for the FIFO write arbiter.
// Holds the arbiter FSM encoding and the default WIDTH / NREQ / MAX_BURST values.
package fifo_arb_pkg;

   localparam int unsigned DEF_WIDTH     = 32;
   localparam int unsigned DEF_NREQ      = 4;
   localparam int unsigned DEF_MAX_BURST = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

endpackage : fifo_arb_pkg

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap-around.
// The first requester found with its request high wins.
module fifo_rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [IDW-1:0]  winner,
   output logic            any_req
);

   int unsigned     cand;
   logic [IDW-1:0]  cand_idx;

   always_comb begin
      winner   = '0;
      any_req  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      // Offset NREQ revisits last_grant itself, so a lone requester can win again.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand     = (32'(last_grant) + k) % NREQ;
         cand_idx = IDW'(cand);
         if (!any_req && req[cand_idx]) begin
            any_req = 1'b1;
            winner  = cand_idx;
         end
      end
   end

endmodule : fifo_rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of FIFO writes.
// Data and handshakes pass combinationally; grant, burst length and priority are registered.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned NREQ      = DEF_NREQ,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_w_enb,
   output logic [WIDTH-1:0]        fifo_d_in,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
);

   localparam int unsigned IDW  = $clog2(NREQ);
   localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

   arb_state_e       state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic [IDW-1:0]   winner;
   logic             any_req;
   logic [CNTW-1:0]  cnt_inc;
   logic             gnt_valid;
   logic             xfer;
   logic [WIDTH-1:0] data_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
   end

   fifo_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req        (req_valid),
      .last_grant (last_q),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign gnt_valid = req_valid[grant_q];
   assign cnt_inc   = cnt_q + CNTW'(1);
   assign fifo_d_in = data_arr[grant_q];
   assign grant_id  = grant_q;
   assign busy      = (state_q == BURST);

   // Next-state and handshake logic; only the granted requester is ever served.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      req_ready  = '0;
      fifo_w_enb = 1'b0;
      xfer       = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = BURST;
               grant_d = winner;
               cnt_d   = '0;
            end
         end
         BURST: begin
            req_ready[grant_q] = !fifo_full;
            xfer               = gnt_valid && !fifo_full;
            fifo_w_enb         = xfer;
            if (!gnt_valid) begin
               state_d = IDLE;
               last_d  = grant_q;
            end else if (xfer) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNTW'(MAX_BURST)) begin
                  state_d = IDLE;
                  last_d  = grant_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset leaves last_grant at NREQ-1 so requester 0 is searched first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level model queues expected
// per-cycle status and write data; an independent monitor pops and compares.
module tb_fifo_wr_arbiter;

   localparam int unsigned W    = 32;
   localparam int unsigned NREQ = 4;
   localparam int unsigned MB   = 8;

   typedef struct packed {
      logic          busy;
      logic [1:0]    gid;
      logic [3:0]    ready;
      logic          wenb;
      logic [W-1:0]  din;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              fifo_full;
   logic              fifo_w_enb;
   logic [W-1:0]      fifo_d_in;
   logic [1:0]        grant_id;
   logic              busy;

   logic              rst1;
   logic [NREQ-1:0]   v1;
   logic [NREQ*W-1:0] d1;
   logic [NREQ-1:0]   rdy1;
   logic              full1;
   logic              wenb1;
   logic [W-1:0]      din1;
   logic [1:0]        gid1;
   logic              busy1;

   int nchecks = 0;
   int nfail   = 0;

   exp_t        sq[$];
   logic [W-1:0] dq[$];
   int          glog[$];
   int          blog[$];
   logic [W-1:0] wlog[$];

   int m_busy  = 0;
   int m_owner = 0;
   int m_last  = NREQ - 1;
   int m_beats = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(NREQ), .MAX_BURST(MB)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_enb(fifo_w_enb),
      .fifo_d_in(fifo_d_in), .grant_id(grant_id), .busy(busy)
   );

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(NREQ), .MAX_BURST(1)) u_dut1 (
      .clk(clk), .reset(rst1), .req_valid(v1), .req_data(d1),
      .req_ready(rdy1), .fifo_full(full1), .fifo_w_enb(wenb1),
      .fifo_d_in(din1), .grant_id(gid1), .busy(busy1)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NREQ*W-1:0] rand_data();
      logic [NREQ*W-1:0] d;
      for (int i = 0; i < NREQ; i++) d[i*W +: W] = $urandom;
      return d;
   endfunction

   // One clock of stimulus plus the reference model's view of that clock.
   task automatic cycle(input logic r, input logic [NREQ-1:0] v, input logic f,
                        input logic [NREQ*W-1:0] d);
      exp_t e;
      int   win;
      @(negedge clk);
      reset     = r;
      req_valid = v;
      fifo_full = f;
      req_data  = d;
      e   = '0;
      win = -1;
      if (r) begin
         m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
         e.din = d[0 +: W];
      end else if (m_busy == 0) begin
         e.gid = 2'(m_owner);
         e.din = d[m_owner*W +: W];
         for (int k = 1; k <= NREQ; k++) begin
            if (win < 0 && v[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
         end
         if (win >= 0) begin
            m_busy = 1; m_owner = win; m_beats = 0;
            glog.push_back(win);
         end
      end else begin
         e.busy = 1'b1;
         e.gid  = 2'(m_owner);
         e.din  = d[m_owner*W +: W];
         e.ready[m_owner] = !f;
         if (v[m_owner] && !f) begin
            e.wenb = 1'b1;
            dq.push_back(d[m_owner*W +: W]);
            wlog.push_back(d[m_owner*W +: W]);
            m_beats++;
         end
         if (!v[m_owner] || m_beats == MB) begin
            m_busy = 0; m_last = m_owner;
            blog.push_back(m_beats);
         end
      end
      sq.push_back(e);
   endtask

   task automatic clear_logs();
      glog.delete(); blog.delete(); wlog.delete();
   endtask

   // Monitor: compares whatever the DUT shows against the queued expectations.
   initial begin
      exp_t e;
      logic [W-1:0] dexp;
      forever begin
         @(negedge clk);
         #2;
         if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("busy", 64'(busy), 64'(e.busy));
            chk("grant_id", 64'(grant_id), 64'(e.gid));
            chk("req_ready", 64'(req_ready), 64'(e.ready));
            chk("fifo_w_enb", 64'(fifo_w_enb), 64'(e.wenb));
            chk("fifo_d_in", 64'(fifo_d_in), 64'(e.din));
            if (fifo_w_enb === 1'b1) begin
               if (dq.size() == 0) chk("write_unexpected", 64'(fifo_d_in), 64'hDEAD_0000);
               else begin
                  dexp = dq.pop_front();
                  chk("write_data", 64'(fifo_d_in), 64'(dexp));
               end
               if (fifo_full === 1'b1) chk("write_while_full", 64'(fifo_w_enb), 64'd0);
            end
         end
      end
   end

   // Single-beat instance: a lone requester gets a one-beat grant every second cycle.
   initial begin
      rst1 = 1'b1; v1 = 4'b0001; full1 = 1'b0; d1 = rand_data();
      repeat (2) @(negedge clk);
      rst1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #2;
         chk("mb1_wenb", 64'(wenb1), 64'(i % 2));
         chk("mb1_busy", 64'(busy1), 64'(i % 2));
         if (wenb1) chk("mb1_data", 64'(din1), 64'(d1[W-1:0]));
         @(negedge clk);
      end
   end

   initial begin
      logic [NREQ*W-1:0] d;
      int n;
      reset = 1'b1; req_valid = '0; fifo_full = 1'b0; req_data = '0;
      repeat (3) cycle(1'b1, '0, 1'b0, rand_data());

      // Two alternating requesters, full-length bursts.
      clear_logs();
      n = 0;
      while (blog.size() < 4 && n < 100) begin cycle(1'b0, 4'b1010, 1'b0, rand_data()); n++; end
      chk("alt_bursts_done", 64'(blog.size()), 64'd4);
      if (glog.size() >= 4) begin
         chk("alt_g0", 64'(glog[0]), 64'd1); chk("alt_g1", 64'(glog[1]), 64'd3);
         chk("alt_g2", 64'(glog[2]), 64'd1); chk("alt_g3", 64'(glog[3]), 64'd3);
      end
      foreach (blog[i]) chk("alt_len", 64'(blog[i]), 64'd8);

      // Requester 2 writes A,B,C then drops valid.
      cycle(1'b0, 4'b0000, 1'b0, rand_data());
      clear_logs();
      d = rand_data(); cycle(1'b0, 4'b0100, 1'b0, d);
      d[2*W +: W] = 32'hA; cycle(1'b0, 4'b0100, 1'b0, d);
      d[2*W +: W] = 32'hB; cycle(1'b0, 4'b0100, 1'b0, d);
      d[2*W +: W] = 32'hC; cycle(1'b0, 4'b0100, 1'b0, d);
      cycle(1'b0, 4'b0000, 1'b0, rand_data());
      cycle(1'b0, 4'b0000, 1'b0, rand_data());
      chk("abc_count", 64'(wlog.size()), 64'd3);
      if (wlog.size() == 3) begin
         chk("abc_0", 64'(wlog[0]), 64'hA); chk("abc_1", 64'(wlog[1]), 64'hB);
         chk("abc_2", 64'(wlog[2]), 64'hC);
      end
      if (blog.size() > 0) chk("abc_len", 64'(blog[0]), 64'd3);

      // Five-cycle full stall after three beats; burst still totals eight.
      clear_logs();
      n = 0;
      while (blog.size() < 1 && n < 40) begin
         cycle(1'b0, 4'b0001, (n >= 4 && n <= 8), rand_data()); n++;
      end
      chk("stall_done", 64'(blog.size()), 64'd1);
      if (blog.size() > 0) chk("stall_len", 64'(blog[0]), 64'd8);
      chk("stall_cycles", 64'(n), 64'd14);

      // All requesters valid after reset: 0,1,2,3,0.
      repeat (2) cycle(1'b1, '0, 1'b0, rand_data());
      clear_logs();
      n = 0;
      while (glog.size() < 5 && n < 100) begin cycle(1'b0, 4'b1111, 1'b0, rand_data()); n++; end
      chk("rr_grants", 64'(glog.size()), 64'd5);
      for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(i % 4));

      // Reset after beat 4 of requester 1's burst.
      repeat (2) cycle(1'b1, '0, 1'b0, rand_data());
      clear_logs();
      repeat (5) cycle(1'b0, 4'b0010, 1'b0, rand_data());
      chk("rst_mid_beats", 64'(wlog.size()), 64'd4);
      if (glog.size() > 0) chk("rst_mid_owner", 64'(glog[0]), 64'd1);
      repeat (2) cycle(1'b1, 4'b1111, 1'b0, rand_data());
      clear_logs();
      repeat (3) cycle(1'b0, 4'b1111, 1'b0, rand_data());
      if (glog.size() > 0) chk("rst_first_grant", 64'(glog[0]), 64'd0);
      else chk("rst_first_grant_seen", 64'(glog.size()), 64'd1);

      // Randomized traffic with back-pressure and occasional reset.
      repeat (2000) cycle(($urandom % 300) == 0, 4'($urandom), ($urandom % 4) == 0, rand_data());
      cycle(1'b0, '0, 1'b0, rand_data());
      @(negedge clk); #3;
      chk("pending_writes", 64'(dq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter
